// File: rtl/truth_table_checker_pkg.sv
// rtl/truth_table_checker_pkg.sv - shared types and constants for the truth table checker
package truth_table_checker_pkg;
  localparam int NUM_VECTORS = 8;
  localparam int RESP_W      = 4;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/truth_table_checker_settle.sv
// rtl/truth_table_checker_settle.sv - settle-time counter with clear and terminal-count flag
module tt_settle_counter #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic terminal_o
);
  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == LAST);
endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - sweeps all 8 {A,B,C} vectors and grades the F3..F0 response
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int          SETTLE   = 1,
  parameter logic [31:0] EXPECTED = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F0,
  input  logic       F1,
  input  logic       F2,
  input  logic       F3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_idx,
  output logic [7:0] fail_mask
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [3:0]          fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]    first_q, first_d;
  logic [7:0]          mask_q, mask_d;
  logic                guard_q;
  logic                start_ok;
  logic                cnt_clear, cnt_en, cnt_term;
  logic [RESP_W-1:0]   resp, exp_nib;

  // A start on the first edge after reset release is dropped.
  assign start_ok = start & ~guard_q;
  assign resp     = {F3, F2, F1, F0};
  assign exp_nib  = EXPECTED[{idx_q, 2'b00} +: RESP_W];

  tt_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (cnt_clear),
    .en_i      (cnt_en),
    .terminal_o(cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    first_d    = first_q;
    mask_d     = mask_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d    = ST_SETTLE;
          idx_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_cnt_d = '0;
          first_d    = '0;
          mask_d     = '0;
          cnt_clear  = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_term) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (resp != exp_nib) begin
          fail_cnt_d    = fail_cnt_q + 4'd1;
          mask_d[idx_q] = 1'b1;
          if (fail_cnt_q == 4'd0) begin
            first_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == 4'd0);
        end else begin
          state_d   = ST_SETTLE;
          idx_d     = idx_q + 1'b1;
          cnt_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      first_q    <= '0;
      mask_q     <= '0;
      guard_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      first_q    <= first_d;
      mask_q     <= mask_d;
      guard_q    <= 1'b0;
    end
  end

  // The stimulus is the vector index itself; it parks at 7 once the sweep ends.
  assign {A, B, C}      = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_cnt_q;
  assign first_fail_idx = first_q;
  assign fail_mask      = mask_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - scoreboard bench for truth_table_checker
module tb_truth_table_checker;
  typedef struct {
    logic       pass;
    logic [3:0] fc;
    logic [2:0] ffi;
    logic [7:0] mask;
    int         lat;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic       f3_force = 1'b0;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  res_t       exp_q[$];
  logic [2:0] abc_exp_q[$];

  logic       a0, b0, c0, a1, b1, c1, a2, b2, c2;
  logic [2:0] busy_w, done_w, pass_w;
  logic [3:0] fc0, fc1, fc2;
  logic [2:0] ffi0, ffi1, ffi2;
  logic [7:0] mask0, mask1, mask2;
  logic       busy_s, done_s, pass_s;
  logic [3:0] fc_s;
  logic [2:0] ffi_s, abc_s;
  logic [7:0] mask_s;

  always #5 clk = ~clk;

  truth_table_checker #(.SETTLE(1), .EXPECTED(32'h7654_3210)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .A(a0), .B(b0), .C(c0),
    .F0(c0), .F1(b0), .F2(a0), .F3(f3_force & ({a0, b0, c0} == 3'd5)),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_count(fc0), .first_fail_idx(ffi0), .fail_mask(mask0));

  truth_table_checker #(.SETTLE(1), .EXPECTED(32'h0000_0000)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .A(a1), .B(b1), .C(c1),
    .F0(c1), .F1(b1), .F2(a1), .F3(1'b0),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_count(fc1), .first_fail_idx(ffi1), .fail_mask(mask1));

  truth_table_checker #(.SETTLE(3), .EXPECTED(32'h7654_3210)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .A(a2), .B(b2), .C(c2),
    .F0(c2), .F1(b2), .F2(a2), .F3(1'b0),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_count(fc2), .first_fail_idx(ffi2), .fail_mask(mask2));

  always_comb begin
    busy_s = busy_w[0]; done_s = done_w[0]; pass_s = pass_w[0];
    fc_s = fc0; ffi_s = ffi0; mask_s = mask0; abc_s = {a0, b0, c0};
    if (sel == 1) begin
      busy_s = busy_w[1]; done_s = done_w[1]; pass_s = pass_w[1];
      fc_s = fc1; ffi_s = ffi1; mask_s = mask1; abc_s = {a1, b1, c1};
    end else if (sel == 2) begin
      busy_s = busy_w[2]; done_s = done_w[2]; pass_s = pass_w[2];
      fc_s = fc2; ffi_s = ffi2; mask_s = mask2; abc_s = {a2, b2, c2};
    end
  end

  // Loopback presents {F3,F2,F1,F0} = {F3, vector index}.
  function automatic res_t model(input logic [31:0] tbl, input bit f5, input int settle);
    res_t r;
    logic [3:0] resp;
    r.fc = 0; r.mask = 0; r.ffi = 0;
    for (int i = 0; i < 8; i++) begin
      resp = 4'(i);
      if (f5 && i == 5) resp[3] = 1'b1;
      if (resp != tbl[4*i +: 4]) begin
        if (r.fc == 0) r.ffi = 3'(i);
        r.fc = r.fc + 4'd1;
        r.mask[i] = 1'b1;
      end
    end
    r.pass = (r.fc == 0);
    r.lat = 8 * (settle + 1) + 1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy_s, 0);
    check({tag, "_done"}, done_s, 0);
    check({tag, "_pass"}, pass_s, 0);
    check({tag, "_fc"}, fc_s, 0);
    check({tag, "_ffi"}, ffi_s, 0);
    check({tag, "_mask"}, mask_s, 0);
    check({tag, "_abc"}, abc_s, 0);
  endtask

  task automatic sweep(input int d, input int settle, input int extra_at);
    res_t e;
    int cyc;
    e = exp_q.pop_front();
    sel = d;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k <= settle; k++) abc_exp_q.push_back(3'(v));
    @(negedge clk);
    start_v[d] = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start_v[d] = (cyc == extra_at);
      if (done_s) break;
      check("busy_during_sweep", busy_s, 1);
      if (abc_exp_q.size() > 0) check("abc_seq", abc_s, abc_exp_q.pop_front());
    end
    start_v[d] = 1'b0;
    check("latency", cyc, e.lat);
    check("abc_queue_drained", abc_exp_q.size(), 0);
    abc_exp_q.delete();
    check("done", done_s, 1);
    check("busy_at_done", busy_s, 0);
    check("pass", pass_s, e.pass);
    check("fail_count", fc_s, e.fc);
    check("first_fail_idx", ffi_s, e.ffi);
    check("fail_mask", mask_s, e.mask);
    check("abc_parked", abc_s, 3'd7);
    repeat (3) @(posedge clk);
    #1;
    check("results_held", {done_s, pass_s, fc_s, ffi_s, mask_s}, {1'b1, e.pass, e.fc, e.ffi, e.mask});
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    @(negedge clk);
    reset = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("start_at_release_ignored", busy_s, 0);

    exp_q.push_back(model(32'h7654_3210, 0, 1));
    sweep(0, 1, 0);

    f3_force = 1'b1;
    exp_q.push_back(model(32'h7654_3210, 1, 1));
    sweep(0, 1, 0);
    f3_force = 1'b0;

    exp_q.push_back(model(32'h0000_0000, 0, 1));
    sweep(1, 1, 0);

    exp_q.push_back(model(32'h7654_3210, 0, 3));
    sweep(2, 3, 10);

    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    n = 0;
    while (abc_s != 3'd4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_vector4", abc_s, 3'd4);
    #2 reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(32'h7654_3210, 0, 1));
    sweep(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
